axis_frame_arb_mux: RTL and testbench

//  Frame-granular arbiter/multiplexer: merges S_COUNT AXI-stream sources onto one output.

---
 rtl/axis_pkg.sv | 22 ++
 rtl/axis_rr_arbiter.sv | 40 ++++
 rtl/axis_frame_arb_mux.sv | 189 ++++++++++++++++++
 tb/tb_axis_frame_arb_mux.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared AXI-stream definitions: arbitration mode encodings, the frame
// arbiter state type and an elaboration-time clog2 helper.
package axis_pkg;

  localparam int ARB_MODE_PRIO = 0;
  localparam int ARB_MODE_RR   = 1;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } arb_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/axis_rr_arbiter.sv
// Combinational request arbiter: round-robin search starting at 'pointer'
// (wrapping) or fixed priority (lowest index). Produces a one-hot grant,
// its encoded index and a valid flag.
module axis_rr_arbiter
  import axis_pkg::*;
#(
  parameter int PORTS  = 4,
  parameter int ARB_RR = ARB_MODE_RR,
  parameter int IW     = clog2(PORTS)
) (
  input  logic [PORTS-1:0] request,
  input  logic [IW-1:0]    pointer,
  output logic [PORTS-1:0] grant,
  output logic [IW-1:0]    grant_index,
  output logic             grant_valid
);

  int idx;

  // First requester found in search order wins
  always_comb begin
    grant       = '0;
    grant_index = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int k = 0; k < PORTS; k++) begin
      if (ARB_RR == ARB_MODE_RR) begin
        idx = (int'(pointer) + k) % PORTS;
      end else begin
        idx = k;
      end
      if (!grant_valid && request[idx]) begin
        grant_valid = 1'b1;
        grant[idx]  = 1'b1;
        grant_index = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/axis_frame_arb_mux.sv
// Frame-granular AXI-stream arbiter/mux. A grant is held from the first
// beat until the tlast beat is accepted, so frames never interleave.
// The output side uses an output register plus a one-entry skid register.
module axis_frame_arb_mux
  import axis_pkg::*;
#(
  parameter int S_COUNT    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int ARB_RR     = ARB_MODE_RR
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [S_COUNT*DATA_WIDTH-1:0] input_axis_tdata,
  input  logic [S_COUNT*KEEP_WIDTH-1:0] input_axis_tkeep,
  input  logic [S_COUNT-1:0]            input_axis_tvalid,
  output logic [S_COUNT-1:0]            input_axis_tready,
  input  logic [S_COUNT-1:0]            input_axis_tlast,
  input  logic [S_COUNT-1:0]            input_axis_tuser,
  output logic [DATA_WIDTH-1:0]         output_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         output_axis_tkeep,
  output logic                          output_axis_tvalid,
  input  logic                          output_axis_tready,
  output logic                          output_axis_tlast,
  output logic                          output_axis_tuser,
  output logic [clog2(S_COUNT)-1:0]     grant_index
);

  localparam int IW = clog2(S_COUNT);

  arb_state_t         state_reg, state_next;
  logic [IW-1:0]      grant_index_reg, grant_index_next;
  logic [S_COUNT-1:0] grant_onehot_reg, grant_onehot_next;
  logic [IW-1:0]      rr_ptr_reg, rr_ptr_next;

  logic [S_COUNT-1:0] arb_grant;
  logic [IW-1:0]      arb_index;
  logic               arb_valid;

  logic                  int_tvalid, int_tlast, int_tuser;
  logic [DATA_WIDTH-1:0] int_tdata;
  logic [KEEP_WIDTH-1:0] int_tkeep;

  logic                  output_ready_int_reg, output_ready_int_early;
  logic                  out_tvalid_reg, out_tvalid_next;
  logic                  out_tlast_reg, out_tuser_reg;
  logic [DATA_WIDTH-1:0] out_tdata_reg;
  logic [KEEP_WIDTH-1:0] out_tkeep_reg;
  logic                  temp_tvalid_reg, temp_tvalid_next;
  logic                  temp_tlast_reg, temp_tuser_reg;
  logic [DATA_WIDTH-1:0] temp_tdata_reg;
  logic [KEEP_WIDTH-1:0] temp_tkeep_reg;
  logic                  store_int_to_output, store_int_to_temp, store_temp_to_output;

  axis_rr_arbiter #(
    .PORTS (S_COUNT),
    .ARB_RR(ARB_RR),
    .IW    (IW)
  ) u_arbiter (
    .request    (input_axis_tvalid),
    .pointer    (rr_ptr_reg),
    .grant      (arb_grant),
    .grant_index(arb_index),
    .grant_valid(arb_valid)
  );

  // Select the granted source's beat fields
  always_comb begin
    int_tdata = input_axis_tdata[int'(grant_index_reg)*DATA_WIDTH +: DATA_WIDTH];
    int_tkeep = input_axis_tkeep[int'(grant_index_reg)*KEEP_WIDTH +: KEEP_WIDTH];
    int_tlast = input_axis_tlast[grant_index_reg];
    int_tuser = input_axis_tuser[grant_index_reg];
  end

  // Grant state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      grant_index_reg  <= '0;
      grant_onehot_reg <= '0;
      rr_ptr_reg       <= '0;
    end else begin
      state_reg        <= state_next;
      grant_index_reg  <= grant_index_next;
      grant_onehot_reg <= grant_onehot_next;
      rr_ptr_reg       <= rr_ptr_next;
    end
  end

  // Arbitrate when idle; while active, pass beats until tlast is accepted
  always_comb begin
    state_next        = state_reg;
    grant_index_next  = grant_index_reg;
    grant_onehot_next = grant_onehot_reg;
    rr_ptr_next       = rr_ptr_reg;
    input_axis_tready = '0;
    int_tvalid        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (arb_valid) begin
          state_next        = ST_ACTIVE;
          grant_index_next  = arb_index;
          grant_onehot_next = arb_grant;
        end
      end
      ST_ACTIVE: begin
        input_axis_tready = grant_onehot_reg & {S_COUNT{output_ready_int_reg}};
        int_tvalid        = input_axis_tvalid[grant_index_reg] & output_ready_int_reg;
        if (int_tvalid && int_tlast) begin
          state_next  = ST_IDLE;
          rr_ptr_next = (grant_index_reg == IW'(S_COUNT - 1)) ? '0 : grant_index_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign output_ready_int_early = output_axis_tready
                                | (~temp_tvalid_reg & ~out_tvalid_reg)
                                | (~temp_tvalid_reg & ~int_tvalid);

  // Route each accepted beat to the output or skid register
  always_comb begin
    out_tvalid_next      = out_tvalid_reg;
    temp_tvalid_next     = temp_tvalid_reg;
    store_int_to_output  = 1'b0;
    store_int_to_temp    = 1'b0;
    store_temp_to_output = 1'b0;
    if (output_ready_int_reg) begin
      if (output_axis_tready || !out_tvalid_reg) begin
        out_tvalid_next     = int_tvalid;
        store_int_to_output = 1'b1;
      end else begin
        temp_tvalid_next  = int_tvalid;
        store_int_to_temp = 1'b1;
      end
    end else if (output_axis_tready) begin
      out_tvalid_next      = temp_tvalid_reg;
      temp_tvalid_next     = 1'b0;
      store_temp_to_output = 1'b1;
    end
  end

  // Output and skid registers; reset clears data too so outputs read 0
  always_ff @(posedge clk) begin
    if (rst) begin
      output_ready_int_reg <= 1'b0;
      out_tvalid_reg       <= 1'b0;
      out_tdata_reg        <= '0;
      out_tkeep_reg        <= '0;
      out_tlast_reg        <= 1'b0;
      out_tuser_reg        <= 1'b0;
      temp_tvalid_reg      <= 1'b0;
      temp_tdata_reg       <= '0;
      temp_tkeep_reg       <= '0;
      temp_tlast_reg       <= 1'b0;
      temp_tuser_reg       <= 1'b0;
    end else begin
      output_ready_int_reg <= output_ready_int_early;
      out_tvalid_reg       <= out_tvalid_next;
      temp_tvalid_reg      <= temp_tvalid_next;
      if (store_int_to_output) begin
        out_tdata_reg <= int_tdata;
        out_tkeep_reg <= int_tkeep;
        out_tlast_reg <= int_tlast;
        out_tuser_reg <= int_tuser;
      end else if (store_temp_to_output) begin
        out_tdata_reg <= temp_tdata_reg;
        out_tkeep_reg <= temp_tkeep_reg;
        out_tlast_reg <= temp_tlast_reg;
        out_tuser_reg <= temp_tuser_reg;
      end
      if (store_int_to_temp) begin
        temp_tdata_reg <= int_tdata;
        temp_tkeep_reg <= int_tkeep;
        temp_tlast_reg <= int_tlast;
        temp_tuser_reg <= int_tuser;
      end
    end
  end

  assign output_axis_tdata  = out_tdata_reg;
  assign output_axis_tkeep  = out_tkeep_reg;
  assign output_axis_tvalid = out_tvalid_reg;
  assign output_axis_tlast  = out_tlast_reg;
  assign output_axis_tuser  = out_tuser_reg;
  assign grant_index        = grant_index_reg;

endmodule

// File: tb/tb_axis_frame_arb_mux.sv
// Self-checking bench for axis_frame_arb_mux: one round-robin instance fed by
// per-source beat lists, plus a fixed-priority instance for the priority case.
module tb_axis_frame_arb_mux;

  localparam int S  = 4;
  localparam int DW = 8;
  localparam int KW = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [S*DW-1:0] in_tdata;
  logic [S*KW-1:0] in_tkeep;
  logic [S-1:0]    in_tvalid, in_tready, in_tlast, in_tuser;
  logic [DW-1:0]   out_tdata;
  logic [KW-1:0]   out_tkeep;
  logic            out_tvalid, out_tready, out_tlast, out_tuser;
  logic [1:0]      grant_idx;

  logic [S*DW-1:0] p_tdata;
  logic [S*KW-1:0] p_tkeep;
  logic [S-1:0]    p_tvalid, p_tready, p_tlast, p_tuser;
  logic [DW-1:0]   p_out_tdata;
  logic [KW-1:0]   p_out_tkeep;
  logic            p_out_tvalid, p_otready, p_out_tlast, p_out_tuser;
  logic [1:0]      p_grant_idx;

  axis_frame_arb_mux #(.S_COUNT(S), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ARB_RR(1)) dut (
    .clk(clk), .rst(rst),
    .input_axis_tdata(in_tdata), .input_axis_tkeep(in_tkeep),
    .input_axis_tvalid(in_tvalid), .input_axis_tready(in_tready),
    .input_axis_tlast(in_tlast), .input_axis_tuser(in_tuser),
    .output_axis_tdata(out_tdata), .output_axis_tkeep(out_tkeep),
    .output_axis_tvalid(out_tvalid), .output_axis_tready(out_tready),
    .output_axis_tlast(out_tlast), .output_axis_tuser(out_tuser),
    .grant_index(grant_idx)
  );

  axis_frame_arb_mux #(.S_COUNT(S), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ARB_RR(0)) dut_prio (
    .clk(clk), .rst(rst),
    .input_axis_tdata(p_tdata), .input_axis_tkeep(p_tkeep),
    .input_axis_tvalid(p_tvalid), .input_axis_tready(p_tready),
    .input_axis_tlast(p_tlast), .input_axis_tuser(p_tuser),
    .output_axis_tdata(p_out_tdata), .output_axis_tkeep(p_out_tkeep),
    .output_axis_tvalid(p_out_tvalid), .output_axis_tready(p_otready),
    .output_axis_tlast(p_out_tlast), .output_axis_tuser(p_out_tuser),
    .grant_index(p_grant_idx)
  );

  typedef struct packed {
    logic [1:0] src;
    logic [7:0] data;
    logic       keep;
    logic       last;
    logic       user;
  } beat_t;

  beat_t src_mem [S][16];
  int    src_rd [S];
  int    src_cnt [S];
  beat_t exp_q [$];
  int    n_checks = 0;
  int    n_pass = 0;
  int    cycle = 0;
  int    inv_viol = 0;
  bit    toggle_mode = 1'b0;

  task automatic reset_sources();
    for (int i = 0; i < S; i++) begin
      src_rd[i]  = 0;
      src_cnt[i] = 0;
    end
  endtask

  task automatic load_beat(input int s, input logic [7:0] d, input logic k,
                           input logic l, input logic u, input bit expect_out);
    beat_t b;
    b = {2'(s), d, k, l, u};
    src_mem[s][src_cnt[s]] = b;
    src_cnt[s]++;
    if (expect_out) exp_q.push_back(b);
  endtask

  task automatic drive_inputs();
    beat_t b;
    for (int i = 0; i < S; i++) begin
      if (src_rd[i] < src_cnt[i]) begin
        b = src_mem[i][src_rd[i]];
        in_tvalid[i] = 1'b1;
        in_tdata[i*DW +: DW] = b.data;
        in_tkeep[i] = b.keep;
        in_tlast[i] = b.last;
        in_tuser[i] = b.user;
      end else begin
        in_tvalid[i] = 1'b0;
        in_tdata[i*DW +: DW] = '0;
        in_tkeep[i] = 1'b0;
        in_tlast[i] = 1'b0;
        in_tuser[i] = 1'b0;
      end
    end
    out_tready = toggle_mode ? ~out_tready : 1'b1;
  endtask

  // One clock: sample handshakes at the negedge, advance sources after the edge
  task automatic step(output bit of, output beat_t ob, output int cc);
    logic [S-1:0] fire;
    @(negedge clk);
    fire = in_tvalid & in_tready;
    of   = out_tvalid & out_tready;
    ob   = {grant_idx, out_tdata, out_tkeep, out_tlast, out_tuser};
    cc   = cycle;
    if ($countones(in_tready) > 1 || $countones(p_tready) > 1) inv_viol++;
    @(posedge clk);
    #1;
    cycle++;
    for (int i = 0; i < S; i++) if (fire[i]) src_rd[i]++;
    drive_inputs();
  endtask

  task automatic pulse_reset();
    reset_sources();
    drive_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_sources();
    drive_inputs();
    p_tdata = '0; p_tkeep = '0; p_tvalid = '0; p_tlast = '0; p_tuser = '0; p_otready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (out_tvalid !== 1'b0) $display("[TB] FAIL reset_tvalid got=%b want=0", out_tvalid); else n_pass++;
    n_checks++; if (out_tdata !== 8'h00) $display("[TB] FAIL reset_tdata got=%h want=00", out_tdata); else n_pass++;
    n_checks++; if (out_tkeep !== 1'b0) $display("[TB] FAIL reset_tkeep got=%b want=0", out_tkeep); else n_pass++;
    n_checks++; if (out_tlast !== 1'b0) $display("[TB] FAIL reset_tlast got=%b want=0", out_tlast); else n_pass++;
    n_checks++; if (out_tuser !== 1'b0) $display("[TB] FAIL reset_tuser got=%b want=0", out_tuser); else n_pass++;
    n_checks++; if (in_tready !== 4'b0000) $display("[TB] FAIL reset_tready got=%b want=0000", in_tready); else n_pass++;
    n_checks++; if (grant_idx !== 2'd0) $display("[TB] FAIL reset_grant got=%0d want=0", grant_idx); else n_pass++;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_frame();
    bit of; beat_t ob, e; int cc;
    int c0;
    int first_cc = -1;
    reset_sources();
    load_beat(0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1);
    load_beat(0, 8'h22, 1'b1, 1'b0, 1'b0, 1'b1);
    load_beat(0, 8'h33, 1'b1, 1'b1, 1'b0, 1'b1);
    drive_inputs();
    c0 = cycle;
    for (int k = 0; k < 30 && exp_q.size() > 0; k++) begin
      step(of, ob, cc);
      if (of) begin
        if (first_cc < 0) first_cc = cc;
        e = exp_q.pop_front();
        n_checks++;
        if (ob !== e) $display("[TB] FAIL single_beat got=%h want=%h", ob, e); else n_pass++;
      end
    end
    n_checks++; if (exp_q.size() != 0) $display("[TB] FAIL single_drain left=%0d want=0", exp_q.size()); else n_pass++;
    n_checks++; if (first_cc - c0 != 2) $display("[TB] FAIL single_latency got=%0d want=2", first_cc - c0); else n_pass++;
  endtask

  task automatic test_round_robin();
    bit of; beat_t ob, e; int cc;
    pulse_reset();
    load_beat(0, 8'hA0, 1'b1, 1'b1, 1'b0, 1'b1);
    load_beat(1, 8'hB1, 1'b1, 1'b1, 1'b0, 1'b1);
    load_beat(2, 8'hC2, 1'b1, 1'b1, 1'b1, 1'b1);
    load_beat(3, 8'hD3, 1'b0, 1'b1, 1'b0, 1'b1);
    load_beat(0, 8'hA4, 1'b1, 1'b1, 1'b0, 1'b1);
    drive_inputs();
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
      step(of, ob, cc);
      if (of) begin
        e = exp_q.pop_front();
        n_checks++;
        if (ob !== e) $display("[TB] FAIL rr_order got=%h want=%h", ob, e); else n_pass++;
      end
    end
    n_checks++; if (exp_q.size() != 0) $display("[TB] FAIL rr_drain left=%0d want=0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_fixed_priority();
    int n_out = 0;
    int s3_ready = 0;
    p_tdata = '0;
    p_tdata[1*DW +: DW] = 8'h1A;
    p_tdata[3*DW +: DW] = 8'h3A;
    p_tkeep = '1; p_tlast = '1; p_tuser = '0; p_otready = 1'b1;
    @(posedge clk);
    #1;
    p_tvalid = 4'b1010;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (p_tready[3]) s3_ready++;
      if (p_out_tvalid && p_otready) begin
        n_out++;
        n_checks++;
        if (p_out_tdata !== 8'h1A) $display("[TB] FAIL prio_data got=%h want=1a", p_out_tdata); else n_pass++;
      end
    end
    n_checks++; if (s3_ready != 0) $display("[TB] FAIL prio_s3_ready got=%0d want=0", s3_ready); else n_pass++;
    n_checks++; if (n_out != 9) $display("[TB] FAIL prio_count got=%0d want=9", n_out); else n_pass++;
    n_checks++; if (p_grant_idx !== 2'd1) $display("[TB] FAIL prio_grant got=%0d want=1", p_grant_idx); else n_pass++;
    p_tvalid = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_no_interleave();
    bit of; beat_t ob, e; int cc;
    reset_sources();
    for (int b = 0; b < 4; b++) load_beat(2, 8'h51 + 8'(b), 1'b1, b == 3, 1'b0, 1'b1);
    drive_inputs();
    for (int k = 0; k < 40 && (k < 4 || exp_q.size() > 0); k++) begin
      if (k == 3) begin
        load_beat(0, 8'h61, 1'b1, 1'b0, 1'b0, 1'b1);
        load_beat(0, 8'h62, 1'b1, 1'b1, 1'b1, 1'b1);
        drive_inputs();
        out_tready = 1'b1;
      end
      step(of, ob, cc);
      if (of) begin
        n_checks++;
        if (exp_q.size() == 0) $display("[TB] FAIL interleave_extra got=%h want=none", ob);
        else begin
          e = exp_q.pop_front();
          if (ob !== e) $display("[TB] FAIL interleave_beat got=%h want=%h", ob, e); else n_pass++;
        end
      end
    end
    n_checks++; if (exp_q.size() != 0) $display("[TB] FAIL interleave_drain left=%0d want=0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit of; beat_t ob, e; int cc;
    int extra = 0;
    reset_sources();
    toggle_mode = 1'b1;
    for (int b = 0; b < 8; b++) load_beat(1, 8'h81 + 8'(b), 1'b1, b == 7, b == 4, 1'b1);
    drive_inputs();
    for (int k = 0; k < 80 && exp_q.size() > 0; k++) begin
      step(of, ob, cc);
      if (of) begin
        e = exp_q.pop_front();
        n_checks++;
        if (ob !== e) $display("[TB] FAIL backpressure_beat got=%h want=%h", ob, e); else n_pass++;
      end
    end
    n_checks++; if (exp_q.size() != 0) $display("[TB] FAIL backpressure_drain left=%0d want=0", exp_q.size()); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      step(of, ob, cc);
      if (of) extra++;
    end
    n_checks++; if (extra != 0) $display("[TB] FAIL backpressure_dup got=%0d want=0", extra); else n_pass++;
    toggle_mode = 1'b0;
    drive_inputs();
  endtask

  task automatic test_reset_mid_frame();
    bit of; beat_t ob, e; int cc;
    reset_sources();
    load_beat(3, 8'h71, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int b = 1; b < 5; b++) load_beat(3, 8'h71 + 8'(b), 1'b1, b == 4, 1'b0, 1'b0);
    drive_inputs();
    for (int k = 0; k < 10 && src_rd[3] < 1; k++) begin
      step(of, ob, cc);
      if (of) begin
        n_checks++;
        $display("[TB] FAIL midrst_early got=%h want=none", ob);
      end
    end
    rst = 1'b1;
    step(of, ob, cc);
    n_checks++;
    if (!of || exp_q.size() == 0) $display("[TB] FAIL midrst_beat1 got_fire=%b want_fire=1", of);
    else begin
      e = exp_q.pop_front();
      if (ob !== e) $display("[TB] FAIL midrst_beat1 got=%h want=%h", ob, e); else n_pass++;
    end
    n_checks++; if (out_tvalid !== 1'b0) $display("[TB] FAIL midrst_tvalid got=%b want=0", out_tvalid); else n_pass++;
    n_checks++; if (out_tdata !== 8'h00) $display("[TB] FAIL midrst_tdata got=%h want=00", out_tdata); else n_pass++;
    n_checks++; if (out_tlast !== 1'b0) $display("[TB] FAIL midrst_tlast got=%b want=0", out_tlast); else n_pass++;
    n_checks++; if (in_tready !== 4'b0000) $display("[TB] FAIL midrst_tready got=%b want=0000", in_tready); else n_pass++;
    reset_sources();
    drive_inputs();
    rst = 1'b0;
    load_beat(3, 8'h91, 1'b1, 1'b0, 1'b0, 1'b1);
    load_beat(3, 8'h92, 1'b1, 1'b0, 1'b1, 1'b1);
    load_beat(3, 8'h93, 1'b1, 1'b1, 1'b0, 1'b1);
    drive_inputs();
    for (int k = 0; k < 30 && exp_q.size() > 0; k++) begin
      step(of, ob, cc);
      if (of) begin
        e = exp_q.pop_front();
        n_checks++;
        if (ob !== e) $display("[TB] FAIL postrst_beat got=%h want=%h", ob, e); else n_pass++;
      end
    end
    n_checks++; if (exp_q.size() != 0) $display("[TB] FAIL postrst_drain left=%0d want=0", exp_q.size()); else n_pass++;
  endtask

  // Run every scenario in order, then report
  initial begin
    out_tready = 1'b1;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_fixed_priority();
    test_no_interleave();
    test_backpressure();
    test_reset_mid_frame();
    n_checks++;
    if (inv_viol != 0) $display("[TB] FAIL ready_onehot violations=%0d want=0", inv_viol); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
